// File: rtl/rv32i_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_arb_pkg
//  Description : Shared types and constants for the rv32i memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_arb_pkg;

    localparam int XLEN  = 32;
    localparam int MASKW = 4;

    // Canonical RV32I NOP (addi x0, x0, 0) returned on an aborted fetch.
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rv32i_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mem_arbiter_if
//  Description : Fetch, load/store and unified memory port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_mem_arbiter_if;
    import rv32i_arb_pkg::*;

    logic             i_req;
    logic [XLEN-1:0]  i_addr;
    logic [XLEN-1:0]  i_rdata;
    logic             i_ack;
    logic             d_req;
    logic             d_we;
    logic [XLEN-1:0]  d_addr;
    logic [XLEN-1:0]  d_wdata;
    logic [MASKW-1:0] d_mask;
    logic [XLEN-1:0]  d_rdata;
    logic             d_ack;
    logic             err;
    logic             mem_req;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [MASKW-1:0] mem_mask;
    logic [XLEN-1:0]  mem_rdata;
    logic             mem_ack;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask,
               mem_rdata, mem_ack,
        output i_rdata, i_ack, d_rdata, d_ack, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

    // Requester and memory side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_mask,
               mem_rdata, mem_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_mask
    );

endinterface
`default_nettype wire

// File: rtl/rv32i_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_arb_timer
//  Description : Clear/enable cycle counter with an expiry flag at LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_arb_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mem_arbiter
//  Description : Fetch/data arbiter onto one single-port memory, data
//                priority with fetch starvation guard. Optional watchdog
//                abort enabled by macro MEM_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               rst,
    rv32i_mem_arbiter_if.slave bus
);
    import rv32i_arb_pkg::*;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_e       state_q,      state_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             mem_req_q,    mem_req_d;
    logic             mem_we_q,     mem_we_d;
    logic [XLEN-1:0]  mem_addr_q,   mem_addr_d;
    logic [XLEN-1:0]  mem_wdata_q,  mem_wdata_d;
    logic [MASKW-1:0] mem_mask_q,   mem_mask_d;
    logic             i_ack_q,      i_ack_d;
    logic             d_ack_q,      d_ack_d;
    logic [XLEN-1:0]  i_rdata_q,    i_rdata_d;
    logic [XLEN-1:0]  d_rdata_q,    d_rdata_d;
    logic             err_q,        err_d;

    logic grant;
    logic busy;
    logic timeout;
    logic i_elig;
    logic d_elig;

    // A request still high in its own ack cycle is the one just served.
    assign i_elig = bus.i_req && !i_ack_q;
    assign d_elig = bus.d_req && !d_ack_q;
    assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
    logic expired;

    rv32i_arb_timer #(
        .WIDTH (8),
        .LIMIT (TIMEOUT - 1)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      (busy && !bus.mem_ack),
        .expired (expired)
    );

    assign timeout = busy && expired;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_elig && !(i_elig && (starve_cnt_q == STARVE_MAX))) begin
                    state_d     = BUSY_D;
                    grant       = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_mask_d  = bus.d_we ? bus.d_mask : '0;
                    if (!bus.i_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (i_elig) begin
                    state_d      = BUSY_I;
                    grant        = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.i_addr;
                    mem_wdata_d  = '0;
                    mem_mask_d   = '0;
                    starve_cnt_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // A same-cycle mem_ack beats watchdog expiry.
                if (bus.mem_ack || timeout) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = !bus.mem_ack;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.mem_ack ? bus.mem_rdata : NOP;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mask  = mem_mask_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_mem_arbiter
//  Description : Scoreboard bench for rv32i_mem_arbiter with a wait-state
//                memory model; watchdog cases need MEM_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;
    import rv32i_arb_pkg::*;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } ack_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_mem_arbiter_if bus ();

    rv32i_mem_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ack_exp_t    ack_q[$];
    mem_exp_t    mem_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          rise_cyc = 0;
    int          mem_ws   = 0;
    bit          mem_hold = 1'b0;
    logic [31:0] mem_rdata_v = '0;
    int          wcnt     = 0;
    logic        mreq_prev = 1'b0;
    mem_exp_t    cur;

    assign bus.mem_rdata = mem_rdata_v;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Memory model: acks after mem_ws wait cycles unless held off.
    always @(negedge clk) begin
        if (bus.mem_req && !rst) begin
            if (!mem_hold && wcnt >= mem_ws) begin
                bus.mem_ack = 1'b1;
                wcnt        = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt        = 0;
        end
    end

    // Memory-side monitor: request fields at rise, then stability while held.
    always @(negedge clk) begin
        if (rst) begin
            mreq_prev = 1'b0;
        end else begin
            if (bus.mem_req && !mreq_prev) begin
                rise_cyc = cyc;
                if (mem_q.size() == 0) begin
                    fail_now("mem_unexpected_req");
                end else begin
                    cur = mem_q.pop_front();
                    chk("mem_we",   {31'd0, bus.mem_we}, {31'd0, cur.we});
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_mask", {28'd0, bus.mem_mask}, {28'd0, cur.mask});
                    if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (bus.mem_req) begin
                chk("mem_hold_addr", bus.mem_addr, cur.addr);
                chk("mem_hold_ctl", {27'd0, bus.mem_we, bus.mem_mask}, {27'd0, cur.we, cur.mask});
                if (cur.we) chk("mem_hold_wdata", bus.mem_wdata, cur.wdata);
            end
            mreq_prev = bus.mem_req;
        end
    end

    // Requester-side monitor: every ack pops one expected completion.
    always @(negedge clk) begin
        ack_exp_t e;
        if (!rst) begin
            if (bus.i_ack && bus.d_ack) begin
                fail_now("dual_ack");
            end else if (bus.i_ack || bus.d_ack) begin
                if (ack_q.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port",  {31'd0, bus.d_ack}, {31'd0, e.is_d});
                    chk("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
                    chk("ack_err",   {31'd0, bus.err}, {31'd0, e.err});
                    chk("ack_latency", cyc - rise_cyc, e.lat);
                    chk("mem_req_at_ack", {31'd0, bus.mem_req}, 32'd0);
                end
            end else if (bus.err) begin
                fail_now("err_without_ack");
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"},   {31'd0, bus.mem_req}, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_mem_mask"},  {28'd0, bus.mem_mask}, 32'd0);
        chk({tag, "_acks_err"},  {29'd0, bus.i_ack, bus.d_ack, bus.err}, 32'd0);
        chk({tag, "_i_rdata"},   bus.i_rdata, 32'd0);
        chk({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
    endtask

    task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask,
                            input logic [31:0] exp_rd, input bit exp_err, input int lat);
        mem_exp_t m;
        ack_exp_t a;
        m.we    = is_d ? we : 1'b0;
        m.addr  = addr;
        m.wdata = wdata;
        m.mask  = (is_d && we) ? mask : 4'b0000;
        mem_q.push_back(m);
        a.is_d  = is_d;
        a.rdata = exp_rd;
        a.err   = exp_err;
        a.lat   = lat;
        ack_q.push_back(a);
    endtask

    task automatic wait_any_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.i_ack || bus.d_ack) && n < 100);
        if (n >= 100) fail_now({name, "_ack_timeout"});
    endtask

    // Single requester transaction; req stays high through its ack cycle.
    task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] mrd, input int ws,
                         input logic [31:0] exp_rd, input bit exp_err, input int lat);
        push_exp(is_d, we, addr, wdata, mask, exp_rd, exp_err, lat);
        mem_ws      = ws;
        mem_rdata_v = mrd;
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
            bus.d_wdata = wdata; bus.d_mask = mask;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        wait_any_ack("issue");
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    // Both requesters raise together; the loser withdraws at the winner's ack.
    task automatic round(input bit exp_d, input int k);
        logic [31:0] ia, da, rd;
        ia = 32'h0000_0300 + 32'(k * 4);
        da = 32'h0000_4000 + 32'(k * 4);
        rd = 32'hD000_0000 | 32'(k);
        push_exp(exp_d, 1'b0, exp_d ? da : ia, 32'd0, 4'b0000, rd, 1'b0, 1);
        mem_ws      = 0;
        mem_rdata_v = rd;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = ia;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
        bus.d_wdata = 32'd0; bus.d_mask = 4'b0000;
        wait_any_ack("round");
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit order [10];
        order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_mask = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch.
        issue(0, 0, 32'h0000_0100, 32'd0, 4'b0000, 32'h0050_0093, 0, 32'h0050_0093, 0, 1);
        // Load with two wait states.
        issue(1, 0, 32'h0000_2000, 32'd0, 4'b1111, 32'h1122_3344, 2, 32'h1122_3344, 0, 3);
        // Store with three wait states: d_rdata keeps the prior load value.
        issue(1, 1, 32'h0000_2004, 32'hAABB_0000, 4'b1100, 32'hDEAD_BEEF, 3, 32'h1122_3344, 0, 4);

        // Contention: starvation guard forces a fetch after four data wins.
        for (int k = 0; k < 10; k++) round(order[k], k);

        // Reset during a load with five wait states.
        mem_q.push_back('{we: 1'b0, addr: 32'h0000_3000, wdata: 32'd0, mask: 4'b0000});
        mem_ws = 5;
        mem_rdata_v = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_3000;
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!bus.mem_req && n < 20);
            if (n >= 20) fail_now("rst_test_no_mem_req");
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(1, 0, 32'h0000_3008, 32'd0, 4'b0000, 32'h55AA_55AA, 1, 32'h55AA_55AA, 0, 2);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: NOP with err, 16 cycles after mem_req rose.
        mem_hold = 1'b1;
        issue(0, 0, 32'h0000_0400, 32'd0, 4'b0000, 32'h1234_5678, 0, 32'h0000_0013, 1, 16);
        mem_hold = 1'b0;
        // Load aborted by the watchdog returns zero.
        mem_hold = 1'b1;
        issue(1, 0, 32'h0000_5000, 32'd0, 4'b0000, 32'h1234_5678, 0, 32'h0000_0000, 1, 16);
        mem_hold = 1'b0;
        // Ack on the expiry cycle wins.
        issue(0, 0, 32'h0000_0404, 32'd0, 4'b0000, 32'hCAFE_0001, 15, 32'hCAFE_0001, 0, 16);
`endif

        repeat (5) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 32'd0);
        chk("mem_queue_drained", mem_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
